// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and data access.
// Data wins ties; each granted access is issued once, waits the fixed RAM latency, then pulses ready.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              mem_stall
);

    // state  | meaning
    // IDLE   | sample requests, grant data first, fetch second
    // ISSUE  | ram_en strobe for the granted access, load latency counter
    // WAIT   | count down RAM latency, capture read data on the last count

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_port_arbiter: WAIT_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              owner_dm_q;
    logic              owner_we_q;
    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       dm_rdata_q;
    logic              if_ready_q;
    logic              dm_ready_q;

    // A requester whose ready is high this cycle is already served and must not be re-granted.
    logic if_pend;
    logic dm_pend;
    assign if_pend = if_req & ~if_ready_q;
    assign dm_pend = dm_req & ~dm_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            owner_dm_q  <= 1'b0;
            owner_we_q  <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            dm_rdata_q  <= 32'd0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (dm_pend) begin
                        owner_dm_q  <= 1'b1;
                        owner_we_q  <= dm_we;
                        ram_addr_q  <= dm_addr;
                        ram_wdata_q <= dm_wdata;
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= dm_we;
                        state_q     <= S_ISSUE;
                    end else if (if_pend) begin
                        owner_dm_q <= 1'b0;
                        owner_we_q <= 1'b0;
                        ram_addr_q <= if_addr;
                        ram_en_q   <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= WAIT_LD;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        // Stores wait the full latency too, but leave dm_rdata untouched.
                        if (owner_dm_q) begin
                            if (!owner_we_q) begin
                                dm_rdata_q <= ram_rdata;
                            end
                            dm_ready_q <= 1'b1;
                        end else begin
                            if_rdata_q <= ram_rdata;
                            if_ready_q <= 1'b1;
                        end
                        cnt_q   <= 4'd0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign mem_stall = if_pend | dm_pend;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at WAIT_CYCLES=1, one at WAIT_CYCLES=4,
// each with a RAM model and a scoreboard of expected completions.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;

    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_ready, dm_ready, ram_en, ram_we, mem_stall;

    logic        b_if_req, b_dm_req, b_dm_we;
    logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
    logic [31:0] b_if_rdata, b_dm_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
    logic        b_if_ready, b_dm_ready, b_ram_en, b_ram_we, b_mem_stall;

    mem_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(32)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .mem_stall(mem_stall)
    );

    mem_port_arbiter #(.WAIT_CYCLES(4), .ADDR_W(32)) u_dut4 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .mem_stall(b_mem_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM models: read data is only valid in the single cycle WAIT_CYCLES after ram_en.
    logic        st_valid = 1'b0;
    logic [31:0] st_addr  = 32'd0;
    logic [31:0] st_data  = 32'd0;
    logic        a_valid  = 1'b0;
    logic [31:0] a_lat    = 32'd0;
    logic [3:0]  b_pipe   = 4'd0;
    logic [31:0] b_lat    = 32'd0;

    function automatic logic [31:0] ram_val(input logic [31:0] ad);
        if (st_valid && ad == st_addr) return st_data;
        case (ad)
            32'h40:  return 32'h8C01_0004;
            32'h44:  return 32'h8C02_0008;
            default: return {ad[15:0], ~ad[15:0]};
        endcase
    endfunction

    always @(posedge clk) begin
        a_valid <= ram_en & ~ram_we;
        if (ram_en & ram_we) begin
            st_valid <= 1'b1;
            st_addr  <= ram_addr;
            st_data  <= ram_wdata;
        end
        if (ram_en & ~ram_we) a_lat <= ram_val(ram_addr);
        b_pipe <= {b_pipe[2:0], b_ram_en & ~b_ram_we};
        if (b_ram_en & ~b_ram_we) b_lat <= ram_val(b_ram_addr);
    end

    assign ram_rdata   = a_valid   ? a_lat : 32'hBAD0_BAD0;
    assign b_ram_rdata = b_pipe[3] ? b_lat : 32'hBAD0_BAD0;

    typedef struct {
        bit          dm;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_a[$];
    exp_t        sb_b[$];
    int          nerr = 0;
    int          nchk = 0;
    int          cyc = 0;
    int          b_last_cyc = -1;
    bit          b_last_dm = 1'b0;
    int          b_left = 0;
    int          b_en_cnt = 0;
    int          b_rdy_cnt = 0;
    logic [31:0] a_last_dm = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_ctl"}, 32'({ram_en, ram_we, if_ready, dm_ready, mem_stall}), 32'd0);
        chk({tag, "_ram_addr"}, ram_addr, 32'd0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    endtask

    task automatic b_gap(input bit is_dm);
        // Same requester re-grants the cycle after ready; the other one is granted in the ready cycle.
        if (b_last_cyc >= 0)
            chk("b_ready_gap", 32'(cyc - b_last_cyc), (b_last_dm == is_dm) ? 32'd7 : 32'd6);
        b_last_cyc = cyc;
        b_last_dm  = is_dm;
        b_rdy_cnt++;
    endtask

    // Advance one cycle, sample #1 after the edge and retire any completions against the scoreboards.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (b_ram_en) b_en_cnt++;
        if (if_ready) begin
            if (sb_a.size() == 0) chk("a_if_unexpected", 32'(if_ready), 32'd0);
            else begin
                e = sb_a.pop_front();
                chk("a_if_owner", 32'(e.dm), 32'd0);
                chk("a_if_rdata", if_rdata, e.data);
            end
        end
        if (dm_ready) begin
            if (sb_a.size() == 0) chk("a_dm_unexpected", 32'(dm_ready), 32'd0);
            else begin
                e = sb_a.pop_front();
                chk("a_dm_owner", 32'(e.dm), 32'd1);
                chk("a_dm_rdata", dm_rdata, e.data);
            end
        end
        if (b_if_ready) begin
            if (sb_b.size() == 0) chk("b_if_unexpected", 32'(b_if_ready), 32'd0);
            else begin
                e = sb_b.pop_front();
                chk("b_if_owner", 32'(e.dm), 32'd0);
                chk("b_if_rdata", b_if_rdata, e.data);
            end
            b_gap(1'b0);
            if (b_left > 0) begin
                b_if_addr = b_if_addr + 32'd4;
                sb_b.push_back('{dm: 1'b0, data: ram_val(b_if_addr)});
                b_left--;
            end else begin
                b_if_req = 1'b0;
            end
        end
        if (b_dm_ready) begin
            if (sb_b.size() == 0) chk("b_dm_unexpected", 32'(b_dm_ready), 32'd0);
            else begin
                e = sb_b.pop_front();
                chk("b_dm_owner", 32'(e.dm), 32'd1);
                chk("b_dm_rdata", b_dm_rdata, e.data);
            end
            b_gap(1'b1);
            b_dm_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'd0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
        b_if_req = 1'b0; b_if_addr = 32'd0; b_dm_req = 1'b0; b_dm_we = 1'b0;
        b_dm_addr = 32'd0; b_dm_wdata = 32'd0;

        // Reset values
        tick(); tick();
        chk_zero_a("reset");
        chk("b_reset_data", b_if_rdata | b_dm_rdata | b_ram_addr | b_ram_wdata, 32'd0);
        chk("b_reset_ctl", 32'({b_ram_en, b_ram_we, b_if_ready, b_dm_ready, b_mem_stall}), 32'd0);
        rst = 1'b0;
        tick();

        // Lone fetch
        if_req = 1'b1; if_addr = 32'h40;
        sb_a.push_back('{dm: 1'b0, data: 32'h8C01_0004});
        #1;
        chk("fetch_stall_t0", 32'(mem_stall), 32'd1);
        tick();
        chk("fetch_ram_en_t1", 32'(ram_en), 32'd1);
        chk("fetch_ram_we_t1", 32'(ram_we), 32'd0);
        chk("fetch_ram_addr_t1", ram_addr, 32'h40);
        chk("fetch_stall_t1", 32'(mem_stall), 32'd1);
        tick();
        chk("fetch_ram_en_t2", 32'(ram_en), 32'd0);
        chk("fetch_stall_t2", 32'(mem_stall), 32'd1);
        tick();
        chk("fetch_ready_t3", 32'(if_ready), 32'd1);
        chk("fetch_rdata_t3", if_rdata, 32'h8C01_0004);
        chk("fetch_stall_t3", 32'(mem_stall), 32'd0);
        if_req = 1'b0;
        tick();
        chk("fetch_ready_pulse", 32'(if_ready), 32'd0);
        chk("fetch_rdata_hold", if_rdata, 32'h8C01_0004);

        // Simultaneous requests: data first, fetch granted in the dm_ready cycle
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h44;
        a_last_dm = ram_val(32'h100);
        sb_a.push_back('{dm: 1'b1, data: a_last_dm});
        sb_a.push_back('{dm: 1'b0, data: 32'h8C02_0008});
        tick();
        chk("sim_ram_en_t1", 32'(ram_en), 32'd1);
        chk("sim_ram_addr_t1", ram_addr, 32'h100);
        tick(); tick();
        chk("sim_dm_ready_t3", 32'(dm_ready), 32'd1);
        chk("sim_stall_t3", 32'(mem_stall), 32'd1);
        dm_req = 1'b0;
        tick();
        chk("sim_ram_en_t4", 32'(ram_en), 32'd1);
        chk("sim_ram_addr_t4", ram_addr, 32'h44);
        tick(); tick();
        chk("sim_if_ready_t6", 32'(if_ready), 32'd1);
        if_req = 1'b0;
        tick();

        // Store
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        sb_a.push_back('{dm: 1'b1, data: a_last_dm});
        tick();
        chk("st_ctl_t1", 32'({ram_en, ram_we}), 32'd3);
        chk("st_ram_addr_t1", ram_addr, 32'h200);
        chk("st_ram_wdata_t1", ram_wdata, 32'hDEAD_BEEF);
        tick();
        chk("st_ctl_t2", 32'({ram_en, ram_we}), 32'd0);
        tick();
        chk("st_dm_ready_t3", 32'(dm_ready), 32'd1);
        chk("st_dm_rdata_kept", dm_rdata, a_last_dm);
        dm_req = 1'b0; dm_we = 1'b0;
        tick();

        // Load back the stored word
        dm_req = 1'b1; dm_addr = 32'h200;
        a_last_dm = 32'hDEAD_BEEF;
        sb_a.push_back('{dm: 1'b1, data: a_last_dm});
        n = 0;
        while (!dm_ready && n < 20) begin tick(); n++; end
        chk("ld_back_latency", 32'(n), 32'd3);
        dm_req = 1'b0;
        tick();

        // Reset in the middle of an access
        if_req = 1'b1; if_addr = 32'h300;
        tick();
        chk("rm_issue", 32'(ram_en), 32'd1);
        tick();
        rst = 1'b1; if_req = 1'b0;
        tick();
        chk_zero_a("rm");
        a_last_dm = 32'd0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rm_no_ready", 32'({if_ready, dm_ready}), 32'd0);
        end
        if_req = 1'b1; if_addr = 32'h40;
        sb_a.push_back('{dm: 1'b0, data: 32'h8C01_0004});
        n = 0;
        while (!if_ready && n < 20) begin tick(); n++; end
        chk("rm_refetch_latency", 32'(n), 32'd3);
        if_req = 1'b0;
        tick();

        // WAIT_CYCLES=4: continuous fetches with a load injected mid-stream
        b_en_cnt = 0;
        b_if_req = 1'b1; b_if_addr = 32'h1000;
        sb_b.push_back('{dm: 1'b0, data: ram_val(32'h1000)});
        b_left = 3;
        tick(); tick(); tick();
        b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 32'h2000;
        sb_b.push_back('{dm: 1'b1, data: ram_val(32'h2000)});
        n = 0;
        while ((sb_b.size() != 0 || b_if_req || b_dm_req) && n < 200) begin tick(); n++; end
        chk("b_sb_empty", 32'(sb_b.size()), 32'd0);
        chk("b_ready_count", 32'(b_rdy_cnt), 32'd5);
        chk("b_ram_en_count", 32'(b_en_cnt), 32'd5);
        tick(); tick();
        chk("a_sb_empty", 32'(sb_a.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
